sipo_frame_reg: RTL and testbench

Parametrised serial-in/parallel-out frame register. It is the successor to the fixed 9-bit SIPO in the UART receive path and sits between the RX bit sampler and the RX FIFO. It adds a runtime frame length, a selectable bit order, a parity check, a bit counter that assembles frames on its own, and a valid/ready output holding register with overrun detection.

---
 rtl/sipo_frame_reg_if.sv | 30 +++
 rtl/sipo_frame_reg.sv | 118 +++++++++++
 tb/tb_sipo_frame_reg.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_reg_if.sv
// Bus between the RX bit sampler (master) and the SIPO frame register (slave).
// Clock and reset are kept as plain ports on the register itself.
interface sipo_frame_reg_if #(
    parameter int WIDTH = 9,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             clear;
    logic             shift;
    logic             serial_data_in;
    logic [CNT_W-1:0] frame_len;
    logic             par_en;
    logic             par_odd;
    logic [WIDTH-1:0] parallel_data_out;
    logic             out_valid;
    logic             out_ready;
    logic             parity_err;
    logic             overrun;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output clear, shift, serial_data_in, frame_len, par_en, par_odd, out_ready,
        input  parallel_data_out, out_valid, parity_err, overrun, busy, bit_cnt
    );

    modport slave (
        input  clear, shift, serial_data_in, frame_len, par_en, par_odd, out_ready,
        output parallel_data_out, out_valid, parity_err, overrun, busy, bit_cnt
    );
endinterface

// File: rtl/sipo_frame_reg.sv
// Serial-in/parallel-out frame register with runtime length, selectable bit order,
// parity check and a valid/ready holding register that flags dropped frames.
module sipo_frame_reg #(
    parameter  int WIDTH     = 9,
    parameter  bit LSB_FIRST = 1'b1,
    localparam int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic            reg_clk,
    input  logic            reg_rst_n,
    sipo_frame_reg_if.slave bus
);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             par_q, par_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;

    logic [CNT_W-1:0] len_req;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] pos;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] frame;
    logic             par_new;
    logic             last_bit;
    logic             accept;

    // The first bit of a frame uses the live frame_len; later bits use the latched copy.
    always_comb begin
        len_req = bus.frame_len;
        if (bus.frame_len == '0 || bus.frame_len > CNT_W'(WIDTH)) begin
            len_req = CNT_W'(WIDTH);
        end
        len_eff  = (bit_cnt_q == '0) ? len_req : len_q;
        pos      = LSB_FIRST ? bit_cnt_q : (len_eff - bit_cnt_q - CNT_W'(1));
        bit_mask = WIDTH'(1) << pos;
        frame    = bus.serial_data_in ? (shreg_q | bit_mask) : shreg_q;
        par_new  = par_q ^ bus.serial_data_in;
        last_bit = (bit_cnt_q == len_eff - CNT_W'(1));
        accept   = valid_q & bus.out_ready;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        par_d     = par_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ovr_d     = ovr_q;

        if (accept) begin
            valid_d = 1'b0;
        end

        if (bus.shift) begin
            len_d = len_eff;
            if (last_bit) begin
                bit_cnt_d = '0;
                shreg_d   = '0;
                par_d     = 1'b0;
                // A stalled consumer keeps its frame; the new one is dropped and flagged.
                if (!valid_q || bus.out_ready) begin
                    data_d  = frame;
                    perr_d  = bus.par_en & (par_new != bus.par_odd);
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                shreg_d   = frame;
                par_d     = par_new;
            end
        end
    end

    always_ff @(posedge reg_clk) begin
        if (!reg_rst_n) begin
            bit_cnt_q <= '0;
            len_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else if (bus.clear) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            len_q     <= len_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.parallel_data_out = data_q;
    assign bus.out_valid         = valid_q;
    assign bus.parity_err        = perr_q;
    assign bus.overrun           = ovr_q;
    assign bus.bit_cnt           = bit_cnt_q;
    assign bus.busy              = (bit_cnt_q != '0);

endmodule

// File: tb/tb_sipo_frame_reg.sv
// Directed bench for sipo_frame_reg: one LSB-first and one MSB-first instance share
// identical stimulus, and a queue-based scoreboard holds the frames each should present.
module tb_sipo_frame_reg;

    localparam int WIDTH = 9;

    logic reg_clk = 1'b0;
    logic reg_rst_n;

    sipo_frame_reg_if #(.WIDTH(WIDTH)) busL ();
    sipo_frame_reg_if #(.WIDTH(WIDTH)) busM ();

    sipo_frame_reg #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dutL (
        .reg_clk   (reg_clk),
        .reg_rst_n (reg_rst_n),
        .bus       (busL)
    );

    sipo_frame_reg #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dutM (
        .reg_clk   (reg_clk),
        .reg_rst_n (reg_rst_n),
        .bus       (busM)
    );

    always #5 reg_clk = ~reg_clk;

    int          checks = 0;
    int          passes = 0;
    logic [9:0]  expL[$];
    logic [9:0]  expM[$];
    logic        mdlValid;
    logic        mdlOvr;
    logic [8:0]  lastL;
    logic        parEn;
    logic        parOdd;
    logic [3:0]  frameLen;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic sh, input logic bitIn, input logic clr,
                                 input logic rstn, input logic rdy);
        busL.shift = sh;           busM.shift = sh;
        busL.serial_data_in = bitIn; busM.serial_data_in = bitIn;
        busL.clear = clr;          busM.clear = clr;
        busL.out_ready = rdy;      busM.out_ready = rdy;
        busL.frame_len = frameLen; busM.frame_len = frameLen;
        busL.par_en = parEn;       busM.par_en = parEn;
        busL.par_odd = parOdd;     busM.par_odd = parOdd;
        reg_rst_n = rstn;
        @(posedge reg_clk);
        #1;
    endtask

    // Bit i of bv is the bit sent on the i-th shift edge.
    task automatic sendFrame(input logic [15:0] bv, input int n, input logic rdyLast,
                             input int lenSwitchAt, input string tag);
        logic [8:0] eL;
        logic [8:0] eM;
        logic       p;
        logic       pe;
        eL = '0;
        eM = '0;
        p  = 1'b0;
        for (int i = 0; i < n; i++) begin
            eL[i]         = bv[i];
            eM[n - 1 - i] = bv[i];
            p             = p ^ bv[i];
        end
        pe = parEn & (p != parOdd);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, bv[i], 1'b0, 1'b1, (i == n - 1) ? rdyLast : 1'b0);
            if (i == lenSwitchAt) frameLen = 4'd9;
        end
        if (!mdlValid || rdyLast) begin
            expL.push_back({pe, eL});
            expM.push_back({pe, eM});
            mdlValid = 1'b1;
            lastL    = eL;
        end else begin
            mdlOvr = 1'b1;
        end
        checkOutput({tag, "_validL"}, 16'(busL.out_valid), 16'(mdlValid));
        checkOutput({tag, "_validM"}, 16'(busM.out_valid), 16'(mdlValid));
        checkOutput({tag, "_ovr"},    16'(busL.overrun),   16'(mdlOvr));
        checkOutput({tag, "_busy"},   16'(busL.busy),      16'd0);
        checkOutput({tag, "_cnt"},    16'(busL.bit_cnt),   16'd0);
    endtask

    task automatic checkFrame(input string tag);
        logic [9:0] eL;
        logic [9:0] eM;
        if (expL.size() == 0 || expM.size() == 0) begin
            checks++;
            $error("[TB] FAIL %s observed=empty_scoreboard expected=frame", tag);
        end else begin
            eL = expL.pop_front();
            eM = expM.pop_front();
            checkOutput({tag, "_dataL"}, 16'(busL.parallel_data_out), 16'(eL[8:0]));
            checkOutput({tag, "_perrL"}, 16'(busL.parity_err),        16'(eL[9]));
            checkOutput({tag, "_dataM"}, 16'(busM.parallel_data_out), 16'(eM[8:0]));
            checkOutput({tag, "_perrM"}, 16'(busM.parity_err),        16'(eM[9]));
        end
    endtask

    task automatic acceptOut(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        mdlValid = 1'b0;
        checkOutput({tag, "_validL"}, 16'(busL.out_valid),         16'd0);
        checkOutput({tag, "_validM"}, 16'(busM.out_valid),         16'd0);
        checkOutput({tag, "_stale"},  16'(busL.parallel_data_out), 16'(lastL));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_data"},  16'(busL.parallel_data_out), 16'd0);
        checkOutput({tag, "_dataM"}, 16'(busM.parallel_data_out), 16'd0);
        checkOutput({tag, "_valid"}, 16'(busL.out_valid),         16'd0);
        checkOutput({tag, "_perr"},  16'(busL.parity_err),        16'd0);
        checkOutput({tag, "_ovr"},   16'(busL.overrun),           16'd0);
        checkOutput({tag, "_busy"},  16'(busL.busy),              16'd0);
        checkOutput({tag, "_cnt"},   16'(busL.bit_cnt),           16'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frameLen = 4'd9;
        parEn    = 1'b0;
        parOdd   = 1'b0;
        mdlValid = 1'b0;
        mdlOvr   = 1'b0;
        lastL    = '0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkResetState("rst");

        // Full-length frame, then a plain accept.
        sendFrame(16'h012D, 9, 1'b0, -1, "full");
        checkFrame("full");
        acceptOut("fullAcc");

        // Parity: five ones fail even parity and pass odd parity.
        parEn  = 1'b1;
        parOdd = 1'b0;
        sendFrame(16'h012D, 9, 1'b0, -1, "parEven");
        checkFrame("parEven");
        acceptOut("parEvenAcc");
        parOdd = 1'b1;
        sendFrame(16'h012D, 9, 1'b0, -1, "parOdd");
        checkFrame("parOdd");
        acceptOut("parOddAcc");

        // Short frame; frame_len raised to 9 mid-frame must be ignored.
        parEn    = 1'b0;
        parOdd   = 1'b0;
        frameLen = 4'd5;
        sendFrame(16'h0013, 5, 1'b0, 1, "short");
        checkFrame("short");
        acceptOut("shortAcc");

        // Overrun, then back-to-back replace on the completion edge, then clear.
        sendFrame(16'h012D, 9, 1'b0, -1, "ovrA");
        sendFrame(16'h01FF, 9, 1'b0, -1, "ovrB");
        checkFrame("ovrHeldA");
        sendFrame(16'h00A5, 9, 1'b1, -1, "ovrC");
        checkFrame("ovrC");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        mdlValid = 1'b0;
        mdlOvr   = 1'b0;
        checkOutput("clr_ovr",   16'(busL.overrun),           16'd0);
        checkOutput("clr_valid", 16'(busL.out_valid),         16'd0);
        checkOutput("clr_perr",  16'(busL.parity_err),        16'd0);
        checkOutput("clr_data",  16'(busL.parallel_data_out), 16'(lastL));

        // Clear together with shift aborts a partial frame.
        parEn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("part_cnt",  16'(busL.bit_cnt), 16'd4);
        checkOutput("part_busy", 16'(busL.busy),    16'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("abort_cnt",   16'(busL.bit_cnt),   16'd0);
        checkOutput("abort_busy",  16'(busL.busy),      16'd0);
        checkOutput("abort_valid", 16'(busL.out_valid), 16'd0);
        sendFrame(16'h01C3, 9, 1'b0, -1, "postClr");
        checkFrame("postClr");

        // Reset mid-frame with valid, parity error and overrun all set.
        sendFrame(16'h00F0, 9, 1'b0, -1, "preRst");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        mdlValid = 1'b0;
        mdlOvr   = 1'b0;
        lastL    = '0;
        checkResetState("midRst");

        // frame_len of 0 selects the full width.
        parEn    = 1'b0;
        frameLen = 4'd0;
        sendFrame(16'h00F0, 9, 1'b0, -1, "len0");
        checkFrame("len0");
        acceptOut("len0Acc");

        // Single-bit frames complete on every shift edge.
        frameLen = 4'd1;
        sendFrame(16'h0001, 1, 1'b0, -1, "len1a");
        checkFrame("len1a");
        sendFrame(16'h0000, 1, 1'b1, -1, "len1b");
        checkFrame("len1b");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
